// File: rtl/taito_ioc.sv
// Taito F2 I/O controller: input bytes, rotary accumulators, coin lockout,
// queued coin-meter pulses, watchdog and reset-extension pulse.
module taito_ioc #(
  parameter int NUM_IN      = 4,
  parameter int NUM_ROT     = 2,
  parameter int ROT_W       = 16,
  parameter int METER_PULSE = 1024,
  parameter int METER_GAP   = 1024,
  parameter int WDOG_CYCLES = 0,
  parameter int RES_PULSE   = 256
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0]           A,
  input  logic                 CSn,
  input  logic                 WEn,
  input  logic [7:0]           Din,
  output logic [7:0]           Dout,
  input  logic [8*NUM_IN-1:0]  IN,
  input  logic                 rotary_inc,
  input  logic                 rotary_abs,
  input  logic [8*NUM_ROT-1:0] rotary,
  output logic [1:0]           COIN_LOCK,
  output logic [1:0]           COINMETER,
  output logic                 RES_OUTn
);

  localparam int MMAX = (METER_PULSE > METER_GAP) ? METER_PULSE : METER_GAP;
  localparam int MCW  = $clog2(MMAX + 1);
  localparam int RCW  = $clog2(RES_PULSE + 1);
  localparam int WDW  = (WDOG_CYCLES > 0) ? $clog2(WDOG_CYCLES + 1) : 1;
  localparam bit WD_EN = (WDOG_CYCLES != 0);

  typedef enum logic [1:0] {IDLE, PULSE, GAP} mstate_e;

  logic             wr, rd, wdog_wr, wd_fire;
  logic [1:0]       req, dec;
  logic [7:0]       rdata, dout_q;
  logic [1:0]       lock_q, meter_q;
  logic [NUM_ROT-1:0] zero_q, zprev_q, zedge;
  logic [ROT_W-1:0] acc_q [NUM_ROT];
  logic [ROT_W-1:0] acc_d [NUM_ROT];
  logic [15:0]      acc16 [NUM_ROT];
  mstate_e          st_q [2];
  logic [3:0]       pend_q [2];
  logic [3:0]       pend_d [2];
  logic [MCW-1:0]   mcnt_q [2];
  logic [WDW-1:0]   wd_q;
  logic [RCW-1:0]   rcnt_q;
  logic             fired_q, resn_q;
  wire              unused_din = ^Din[6:4];

  function automatic logic [ROT_W-1:0] sx(input logic [7:0] v);
    return {{(ROT_W-8){v[7]}}, v};
  endfunction

  assign wr      = !CSn && !WEn;
  assign rd      = !CSn && WEn;
  assign wdog_wr = wr && (A == 6'h12);
  assign req     = (wr && A == 6'h10) ? Din[3:2] : 2'b00;
  assign zedge   = zero_q & ~zprev_q;
  assign wd_fire = WD_EN && resn_q && !wdog_wr && (wd_q == WDW'(1));

  assign Dout      = dout_q;
  assign COIN_LOCK = lock_q;
  assign COINMETER = meter_q;
  assign RES_OUTn  = resn_q;

  // A delta on the zero edge is added to a cleared accumulator
  always_comb begin
    for (int c = 0; c < NUM_ROT; c++) begin
      acc_d[c] = acc_q[c];
      acc16[c] = 16'(acc_q[c]);
      if (rotary_abs)
        acc_d[c] = sx(rotary[8*c +: 8]);
      else if (rotary_inc)
        acc_d[c] = (zedge[c] ? '0 : acc_q[c]) + sx(rotary[8*c +: 8]);
      else if (zedge[c])
        acc_d[c] = '0;
    end
  end

  always_comb begin
    for (int m = 0; m < 2; m++) begin
      dec[m] = (pend_q[m] != 4'd0) &&
               ((st_q[m] == IDLE) ||
                (st_q[m] == GAP && mcnt_q[m] == '0));
      pend_d[m] = pend_q[m];
      if (req[m] && !dec[m] && pend_q[m] != 4'hF)
        pend_d[m] = pend_q[m] + 4'd1;
      else if (dec[m] && !req[m])
        pend_d[m] = pend_q[m] - 4'd1;
    end
  end

  always_comb begin
    rdata = '0;
    for (int k = 0; k < NUM_IN; k++)
      if (A == 6'(k)) rdata = IN[8*k +: 8];
    case (A)
      6'h10:   rdata = {4'b0, meter_q, lock_q};
      6'h11:   rdata[NUM_ROT-1:0] = zero_q;
      6'h12:   rdata[0] = fired_q;
      6'h13:   rdata = {pend_q[1], pend_q[0]};
      default: ;
    endcase
    for (int c = 0; c < NUM_ROT; c++) begin
      if (A == 6'(32 + 2*c) && !zero_q[c]) rdata = acc16[c][7:0];
      if (A == 6'(33 + 2*c) && !zero_q[c]) rdata = acc16[c][15:8];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dout_q  <= '0;
      lock_q  <= '0;
      zero_q  <= '0;
      zprev_q <= '0;
      for (int c = 0; c < NUM_ROT; c++) acc_q[c] <= '0;
    end else begin
      if (rd) dout_q <= rdata;
      if (wr && A == 6'h10) lock_q <= Din[1:0];
      if (wr && A == 6'h11) zero_q <= Din[NUM_ROT-1:0];
      zprev_q <= zero_q;
      for (int c = 0; c < NUM_ROT; c++) acc_q[c] <= acc_d[c];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      meter_q <= '0;
      for (int m = 0; m < 2; m++) begin
        st_q[m]   <= IDLE;
        pend_q[m] <= '0;
        mcnt_q[m] <= '0;
      end
    end else begin
      for (int m = 0; m < 2; m++) begin
        pend_q[m] <= pend_d[m];
        unique case (st_q[m])
          IDLE:
            if (dec[m]) begin
              st_q[m]    <= PULSE;
              meter_q[m] <= 1'b1;
              mcnt_q[m]  <= MCW'(METER_PULSE - 1);
            end
          PULSE:
            if (mcnt_q[m] == '0) begin
              st_q[m]    <= GAP;
              meter_q[m] <= 1'b0;
              mcnt_q[m]  <= MCW'(METER_GAP - 1);
            end else begin
              mcnt_q[m] <= mcnt_q[m] - MCW'(1);
            end
          GAP:
            if (mcnt_q[m] != '0) begin
              mcnt_q[m] <= mcnt_q[m] - MCW'(1);
            end else if (dec[m]) begin
              st_q[m]    <= PULSE;
              meter_q[m] <= 1'b1;
              mcnt_q[m]  <= MCW'(METER_PULSE - 1);
            end else begin
              st_q[m] <= IDLE;
            end
          default: st_q[m] <= IDLE;
        endcase
      end
    end
  end

  // Watchdog count is frozen while the reset pulse is being driven
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_q    <= WDW'(WDOG_CYCLES);
      fired_q <= 1'b0;
      rcnt_q  <= RCW'(RES_PULSE);
      resn_q  <= 1'b0;
    end else begin
      if (wd_fire) begin
        rcnt_q <= RCW'(RES_PULSE);
        resn_q <= 1'b0;
      end else if (rcnt_q != '0) begin
        rcnt_q <= rcnt_q - RCW'(1);
        resn_q <= (rcnt_q == RCW'(1));
      end else begin
        resn_q <= 1'b1;
      end
      if (wdog_wr || wd_fire)
        wd_q <= WDW'(WDOG_CYCLES);
      else if (WD_EN && resn_q)
        wd_q <= wd_q - WDW'(1);
      if (wd_fire)
        fired_q <= 1'b1;
      else if (wdog_wr && Din[7])
        fired_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_taito_ioc.sv
// Directed bench for taito_ioc: bus reads, rotary, zero edge,
// coin meters, watchdog and reset extension.
module tb_taito_ioc;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  A;
  logic        CSn, WEn;
  logic [7:0]  Din, Dout;
  logic [31:0] IN;
  logic        rotary_inc, rotary_abs;
  logic [15:0] rotary;
  logic [1:0]  COIN_LOCK, COINMETER;
  logic        RES_OUTn;

  int errors = 0;
  int checks = 0;

  taito_ioc #(
    .NUM_IN(4), .NUM_ROT(2), .ROT_W(16),
    .METER_PULSE(4), .METER_GAP(2),
    .WDOG_CYCLES(100), .RES_PULSE(8)
  ) dut (
    .clk(clk), .reset(reset), .A(A), .CSn(CSn), .WEn(WEn),
    .Din(Din), .Dout(Dout), .IN(IN),
    .rotary_inc(rotary_inc), .rotary_abs(rotary_abs),
    .rotary(rotary), .COIN_LOCK(COIN_LOCK),
    .COINMETER(COINMETER), .RES_OUTn(RES_OUTn)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [5:0] a, input logic [7:0] d);
    A = a; Din = d; CSn = 1'b0; WEn = 1'b0;
    @(negedge clk);
    CSn = 1'b1; WEn = 1'b1;
  endtask

  task automatic rd(input logic [5:0] a, output logic [7:0] d);
    A = a; CSn = 1'b0; WEn = 1'b1;
    @(negedge clk);
    CSn = 1'b1;
    d = Dout;
  endtask

  task automatic res_len(input string tag);
    int n;
    n = RES_OUTn ? 0 : 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (RES_OUTn) break;
      n++;
    end
    check(tag, n, 8);
  endtask

  initial begin
    logic [7:0] d;
    int first, nlow;
    bit mexp [18] = '{1,1,0,0,1,1,1,1,0,0,1,1,1,1,0,0,0,0};
    int pexp [18] = '{2,2,2,2,2,1,1,1,1,1,1,0,0,0,0,0,0,0};

    reset = 1'b1; A = '0; CSn = 1'b1; WEn = 1'b1; Din = '0;
    IN = 32'h44332211; rotary = '0;
    rotary_inc = 1'b0; rotary_abs = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_dout", Dout, 8'h00);
    check("rst_lock", COIN_LOCK, 2'b00);
    check("rst_meter", COINMETER, 2'b00);
    check("rst_resn", RES_OUTn, 1'b0);
    reset = 1'b0;
    res_len("res_ext");

    rd(6'h00, d); check("in0", d, 8'h11);
    rd(6'h01, d); check("in1", d, 8'h22);
    rd(6'h02, d); check("in2", d, 8'h33);
    rd(6'h03, d); check("in3", d, 8'h44);
    rd(6'h04, d); check("unmap4", d, 8'h00);
    rd(6'h05, d); check("unmap5", d, 8'h00);

    wr(6'h10, 8'h03);
    check("lock_out", COIN_LOCK, 2'b11);
    rd(6'h10, d); check("ctrl_rd", d, 8'h03);
    wr(6'h10, 8'h00);
    check("lock_clr", COIN_LOCK, 2'b00);

    rotary = 16'h00FE; rotary_inc = 1'b1;
    repeat (3) @(negedge clk);
    rotary_inc = 1'b0;
    rd(6'h20, d); check("rot_lo", d, 8'hFA);
    rd(6'h21, d); check("rot_hi", d, 8'hFF);
    rd(6'h22, d); check("rot1_lo", d, 8'h00);

    rotary = 16'h0005; rotary_abs = 1'b1;
    @(negedge clk);
    rotary_abs = 1'b0;
    rd(6'h20, d); check("abs_lo", d, 8'h05);
    rd(6'h21, d); check("abs_hi", d, 8'h00);

    rotary = 16'h0003; rotary_inc = 1'b1;
    wr(6'h11, 8'h01);
    repeat (2) @(negedge clk);
    rotary_inc = 1'b0;
    rd(6'h20, d); check("zero_lo", d, 8'h00);
    rd(6'h11, d); check("zero_rd", d, 8'h01);
    wr(6'h11, 8'h00);
    rd(6'h20, d); check("zedge_lo", d, 8'h06);
    rd(6'h21, d); check("zedge_hi", d, 8'h00);

    repeat (3) wr(6'h10, 8'h04);
    for (int k = 0; k < 18; k++) begin
      rd(6'h13, d);
      check($sformatf("meter_%0d", k), COINMETER[0], mexp[k]);
      check($sformatf("pend_%0d", k), d, pexp[k]);
    end
    check("meter1_idle", COINMETER[1], 1'b0);

    repeat (19) wr(6'h10, 8'h04);
    rd(6'h13, d); check("pend_sat", d, 8'h0F);
    check("meter_on", COINMETER[0], 1'b1);

    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_meter", COINMETER, 2'b00);
    check("mid_rst_resn", RES_OUTn, 1'b0);
    reset = 1'b0;
    res_len("res_ext2");
    rd(6'h13, d); check("pend_rst", d, 8'h00);
    rd(6'h12, d); check("wd_rst", d, 8'h00);

    wr(6'h12, 8'h80);
    first = 0; nlow = 0;
    for (int i = 1; i <= 120; i++) begin
      @(negedge clk);
      if (!RES_OUTn) begin
        nlow++;
        if (first == 0) first = i;
      end
    end
    check("wd_first", first, 100);
    check("wd_len", nlow, 8);
    rd(6'h12, d); check("wd_fired", d, 8'h01);
    wr(6'h12, 8'h80);
    rd(6'h12, d); check("wd_clr", d, 8'h00);

    nlow = 0;
    repeat (6) begin
      wr(6'h12, 8'h00);
      repeat (49) begin
        @(negedge clk);
        if (!RES_OUTn) nlow++;
      end
    end
    check("wd_kicked", nlow, 0);
    rd(6'h12, d); check("wd_nofire", d, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
